// File: rtl/flght_mode_ctrl.sv
// ---------------------------------------------------------------------------
// flght_mode_ctrl
//   Flight mode sequencer: IDLE -> CAL (inertial calibration) -> RUN (ramped
//   thrust delivery) with a FAULT state for calibration timeout or loss of
//   inertial data. Every output is registered.
//
// Parameters
//   CAL_TMO_CYC  cycles allowed in CAL before a calibration fault
//   VLD_TMO_CYC  maximum cycles between vld pulses in RUN before a fault
//   RAMP_STEP    maximum thrust change per vld pulse
//
// Ports
//   clk           system clock, posedge
//   rst_n         asynchronous active-low reset
//   strt_cal      one-cycle request to begin calibration (IDLE/FAULT only)
//   cal_done      calibration complete (honoured only in CAL)
//   vld           new inertial reading pulse
//   mtrs_off_cmd  stop motors; highest priority in CAL and RUN
//   thrst_cmd     requested thrust (unsigned 9 bit)
//   inertial_cal  high only while in CAL
//   mtrs_off      motors forced to zero (IDLE, FAULT)
//   thrst         ramped thrust
//   ctrl_vld      one-cycle strobe, thrst updated in the same cycle
//   cal_err       sticky calibration timeout flag
//   vld_err       sticky inertial-loss flag
//   st            state: IDLE=0, CAL=1, RUN=2, FAULT=3
// ---------------------------------------------------------------------------
module flght_mode_ctrl #(
  parameter int CAL_TMO_CYC = 1000000,
  parameter int VLD_TMO_CYC = 65535,
  parameter int RAMP_STEP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strt_cal,
  input  logic       cal_done,
  input  logic       vld,
  input  logic       mtrs_off_cmd,
  input  logic [8:0] thrst_cmd,
  output logic       inertial_cal,
  output logic       mtrs_off,
  output logic [8:0] thrst,
  output logic       ctrl_vld,
  output logic       cal_err,
  output logic       vld_err,
  output logic [1:0] st
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CAL   = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int CW = $clog2(CAL_TMO_CYC + 1);
  localparam int VW = $clog2(VLD_TMO_CYC + 1);
  localparam logic [CW-1:0] CAL_LAST = CW'(CAL_TMO_CYC - 1);
  localparam logic [VW-1:0] VLD_LAST = VW'(VLD_TMO_CYC - 1);
  localparam logic [9:0]    STEP10   = 10'(RAMP_STEP);

  state_t        state, state_next;
  logic [CW-1:0] cal_tmr, cal_tmr_next;
  logic [VW-1:0] wd_tmr, wd_tmr_next;
  logic [8:0]    thrst_next;
  logic          ctrl_vld_next, cal_err_next, vld_err_next;
  logic [9:0]    up_sum, dn_diff;
  logic [8:0]    ramp_val;

  // Ramp one step toward thrst_cmd. The 10-bit intermediates keep
  // thrst+RAMP_STEP from wrapping and floor the subtraction at zero; the
  // result is then clamped so it never passes thrst_cmd.
  always_comb begin
    up_sum  = {1'b0, thrst} + STEP10;
    dn_diff = ({1'b0, thrst} >= STEP10) ? ({1'b0, thrst} - STEP10) : 10'd0;
    if (thrst < thrst_cmd) begin
      ramp_val = (up_sum > {1'b0, thrst_cmd}) ? thrst_cmd : up_sum[8:0];
    end else if (thrst > thrst_cmd) begin
      ramp_val = (dn_diff < {1'b0, thrst_cmd}) ? thrst_cmd : dn_diff[8:0];
    end else begin
      ramp_val = thrst_cmd;
    end
  end

  // Next state and next output values. Timers default to zero so any state
  // change (or leaving the state that uses them) clears them.
  always_comb begin
    state_next    = state;
    thrst_next    = '0;
    ctrl_vld_next = 1'b0;
    cal_err_next  = cal_err;
    vld_err_next  = vld_err;
    cal_tmr_next  = '0;
    wd_tmr_next   = '0;

    case (state)
      S_IDLE: begin
        if (strt_cal) state_next = S_CAL;
      end

      S_CAL: begin
        if (mtrs_off_cmd) begin
          state_next = S_IDLE;
        end else if (cal_done) begin
          state_next = S_RUN;
        end else if (cal_tmr == CAL_LAST) begin
          state_next   = S_FAULT;
          cal_err_next = 1'b1;
        end else begin
          cal_tmr_next = (cal_tmr == '1) ? cal_tmr : cal_tmr + 1'b1;
        end
      end

      S_RUN: begin
        thrst_next = thrst;
        if (mtrs_off_cmd) begin
          state_next = S_IDLE;
          thrst_next = '0;
        end else if (vld) begin
          // vld beats a coincident watchdog expiry
          thrst_next    = ramp_val;
          ctrl_vld_next = 1'b1;
        end else if (wd_tmr == VLD_LAST) begin
          state_next   = S_FAULT;
          vld_err_next = 1'b1;
          thrst_next   = '0;
        end else begin
          wd_tmr_next = (wd_tmr == '1) ? wd_tmr : wd_tmr + 1'b1;
        end
      end

      S_FAULT: begin
        if (strt_cal) begin
          state_next   = S_CAL;
          cal_err_next = 1'b0;
          vld_err_next = 1'b0;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cal_tmr      <= '0;
      wd_tmr       <= '0;
      thrst        <= '0;
      ctrl_vld     <= 1'b0;
      cal_err      <= 1'b0;
      vld_err      <= 1'b0;
      mtrs_off     <= 1'b1;
      inertial_cal <= 1'b0;
    end else begin
      state        <= state_next;
      cal_tmr      <= cal_tmr_next;
      wd_tmr       <= wd_tmr_next;
      thrst        <= thrst_next;
      ctrl_vld     <= ctrl_vld_next;
      cal_err      <= cal_err_next;
      vld_err      <= vld_err_next;
      mtrs_off     <= (state_next == S_IDLE) || (state_next == S_FAULT);
      inertial_cal <= (state_next == S_CAL);
    end
  end

  assign st = state;

endmodule

// File: tb/tb_flght_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flght_mode_ctrl
//   Directed bench for flght_mode_ctrl (CAL_TMO_CYC=100, VLD_TMO_CYC=50,
//   RAMP_STEP=8). A cycle-level behavioural model is compared against the
//   DUT on every falling edge; directed steps also check hand-computed
//   literal values. Inputs change 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_flght_mode_ctrl;

  localparam int CAL_TMO = 100;
  localparam int VLD_TMO = 50;
  localparam int STEP    = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strt_cal, cal_done, vld, mtrs_off_cmd;
  logic [8:0] thrst_cmd;
  logic       inertial_cal, mtrs_off, ctrl_vld, cal_err, vld_err;
  logic [8:0] thrst;
  logic [1:0] st;

  int n_checks = 0;
  int n_fail   = 0;
  int ic_cnt   = 0;

  flght_mode_ctrl #(
    .CAL_TMO_CYC(CAL_TMO),
    .VLD_TMO_CYC(VLD_TMO),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .strt_cal    (strt_cal),
    .cal_done    (cal_done),
    .vld         (vld),
    .mtrs_off_cmd(mtrs_off_cmd),
    .thrst_cmd   (thrst_cmd),
    .inertial_cal(inertial_cal),
    .mtrs_off    (mtrs_off),
    .thrst       (thrst),
    .ctrl_vld    (ctrl_vld),
    .cal_err     (cal_err),
    .vld_err     (vld_err),
    .st          (st)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 calibrating, 2 running, 3 fault.
  // age: cycles already spent in the current mode (running: since last vld).
  int m_mode = 0;
  int m_age  = 0;
  int m_thr  = 0;
  bit m_cv   = 0;
  bit m_ce   = 0;
  bit m_ve   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_thr = 0; m_cv = 0; m_ce = 0; m_ve = 0;
    end else begin
      int prev;
      prev = m_mode;
      m_cv = 0;
      m_age = m_age + 1;
      if (m_mode == 0) begin
        if (strt_cal) m_mode = 1;
      end else if (m_mode == 1) begin
        if (mtrs_off_cmd)          m_mode = 0;
        else if (cal_done)         m_mode = 2;
        else if (m_age == CAL_TMO) begin m_mode = 3; m_ce = 1; end
      end else if (m_mode == 2) begin
        if (mtrs_off_cmd) begin
          m_mode = 0; m_thr = 0;
        end else if (vld) begin
          int c;
          c = int'(thrst_cmd);
          if (c > m_thr) m_thr = (m_thr + STEP > c) ? c : m_thr + STEP;
          else           m_thr = (m_thr - STEP < c) ? c : m_thr - STEP;
          m_cv = 1;
          m_age = 0;
        end else if (m_age == VLD_TMO) begin
          m_mode = 3; m_ve = 1; m_thr = 0;
        end
      end else begin
        if (strt_cal) begin m_mode = 1; m_ce = 0; m_ve = 0; end
      end
      if (m_mode != prev) m_age = 0;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cmp("cyc_st",      int'(st),           m_mode);
      cmp("cyc_thrst",   int'(thrst),        m_thr);
      cmp("cyc_ctrlvld", int'(ctrl_vld),     int'(m_cv));
      cmp("cyc_mtrsoff", int'(mtrs_off),     int'(m_mode == 0 || m_mode == 3));
      cmp("cyc_inercal", int'(inertial_cal), int'(m_mode == 1));
      cmp("cyc_calerr",  int'(cal_err),      int'(m_ce));
      cmp("cyc_vlderr",  int'(vld_err),      int'(m_ve));
      if (inertial_cal) ic_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end else begin
      $display("chk %-18s t=%0t value=%0d ok", name, $time, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vld_pulse();
    vld = 1'b1; tick(); vld = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st"},      int'(st),           0);
    chk({tag, "_mtrsoff"}, int'(mtrs_off),     1);
    chk({tag, "_inercal"}, int'(inertial_cal), 0);
    chk({tag, "_thrst"},   int'(thrst),        0);
    chk({tag, "_ctrlvld"}, int'(ctrl_vld),     0);
    chk({tag, "_calerr"},  int'(cal_err),      0);
    chk({tag, "_vlderr"},  int'(vld_err),      0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int exp_up[4];
    int exp_dn[4];
    exp_up = '{8, 16, 24, 30};
    exp_dn = '{22, 14, 6, 0};

    rst_n = 1'b0; strt_cal = 1'b0; cal_done = 1'b0; vld = 1'b0;
    mtrs_off_cmd = 1'b0; thrst_cmd = 9'd0;
    #22;
    chk_reset_vals("por");
    tick();
    rst_n = 1'b1;
    ticks(3);
    chk("idle_hold_st", int'(st), 0);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("cal_done_in_idle", int'(st), 0);

    // strt_cal, then cal_done 20 cycles later
    ic_cnt = 0;
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    chk("cal_entry_st", int'(st), 1);
    chk("cal_entry_ic", int'(inertial_cal), 1);
    ticks(19);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("run_entry_st", int'(st), 2);
    chk("run_entry_thrst", int'(thrst), 0);
    chk("run_entry_ic", int'(inertial_cal), 0);
    tick();
    chk("cal_cycles", ic_cnt, 20);

    // strt_cal ignored in RUN
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    chk("strt_in_run_st", int'(st), 2);

    // ramp up to 30, then down to 0
    thrst_cmd = 9'd30;
    for (int i = 0; i < 4; i++) begin
      vld_pulse();
      chk("ramp_up_thrst", int'(thrst), exp_up[i]);
      chk("ramp_up_cv", int'(ctrl_vld), 1);
      tick();
      chk("ramp_up_cv_low", int'(ctrl_vld), 0);
    end
    thrst_cmd = 9'd0;
    for (int i = 0; i < 4; i++) begin
      vld_pulse();
      chk("ramp_dn_thrst", int'(thrst), exp_dn[i]);
      chk("ramp_dn_cv", int'(ctrl_vld), 1);
      tick();
    end

    // watchdog expiry with vld withheld
    thrst_cmd = 9'd100;
    vld_pulse();
    chk("wd_pre_thrst", int'(thrst), 8);
    ticks(49);
    chk("wd_edge_st", int'(st), 2);
    tick();
    chk("wd_fault_st", int'(st), 3);
    chk("wd_fault_verr", int'(vld_err), 1);
    chk("wd_fault_thrst", int'(thrst), 0);
    chk("wd_fault_moff", int'(mtrs_off), 1);
    mtrs_off_cmd = 1'b1; tick(); mtrs_off_cmd = 1'b0;
    chk("fault_moffcmd_st", int'(st), 3);

    // re-enter CAL and RUN, then vld on the expiry cycle
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    chk("fault_exit_st", int'(st), 1);
    chk("fault_exit_verr", int'(vld_err), 0);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("rerun_st", int'(st), 2);
    ticks(49);
    vld_pulse();
    chk("wd_race_st", int'(st), 2);
    chk("wd_race_cv", int'(ctrl_vld), 1);
    chk("wd_race_verr", int'(vld_err), 0);
    chk("wd_race_thrst", int'(thrst), 8);

    // ramp to 200, then mtrs_off_cmd together with vld
    thrst_cmd = 9'd200;
    for (int i = 0; i < 24; i++) begin
      vld_pulse();
      tick();
    end
    chk("at_200_thrst", int'(thrst), 200);
    mtrs_off_cmd = 1'b1; vld = 1'b1; tick(); mtrs_off_cmd = 1'b0; vld = 1'b0;
    chk("off_st", int'(st), 0);
    chk("off_thrst", int'(thrst), 0);
    chk("off_cv", int'(ctrl_vld), 0);
    chk("off_moff", int'(mtrs_off), 1);

    // calibration timeout
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    ticks(99);
    chk("caltmo_edge_st", int'(st), 1);
    tick();
    chk("caltmo_st", int'(st), 3);
    chk("caltmo_cerr", int'(cal_err), 1);
    chk("caltmo_moff", int'(mtrs_off), 1);
    chk("caltmo_ic", int'(inertial_cal), 0);
    ticks(2);
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    chk("caltmo_clr_st", int'(st), 1);
    chk("caltmo_clr_cerr", int'(cal_err), 0);

    // asynchronous reset mid-CAL, checked between clock edges
    ticks(5);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    rst_n = 1'b1;
    ticks(3);
    chk("post_rst_st", int'(st), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flght_mode_ctrl.md
FLGHT_MODE_CTRL -- requirements
Module: flght_mode_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- CAL_TMO_CYC, 1000000: cycles allowed for inertial calibration before fault.
- VLD_TMO_CYC, 65535: maximum cycles between vld pulses while running before fault.
- RAMP_STEP, 8: maximum thrust change per vld pulse.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single system clock, all logic on posedge.
- rst_n, in, 1: asynchronous active-low reset.
- strt_cal, in, 1: one-cycle request to begin calibration.
- cal_done, in, 1: inertial interface reports calibration complete.
- vld, in, 1: new valid inertial reading pulse.
- mtrs_off_cmd, in, 1: command to stop motors.
- thrst_cmd, in, 9: unsigned requested thrust.
- inertial_cal, out, 1: motors held at calibration speed, high only in CAL.
- mtrs_off, out, 1: motors forced to zero.
- thrst, out, 9: unsigned ramped thrust to the flight-control math.
- ctrl_vld, out, 1: one-cycle update strobe to the flight-control math.
- cal_err, out, 1: sticky calibration-timeout flag.
- vld_err, out, 1: sticky inertial-loss flag.
- st, out, 2: current state encoding (IDLE=0, CAL=1, RUN=2, FAULT=3).

Function
REQ-003 The block SHALL implement a four-state machine IDLE, CAL, RUN and FAULT, with every output registered.

REQ-004 In IDLE the block SHALL hold mtrs_off=1, inertial_cal=0, thrst=0 and ctrl_vld=0, and SHALL go to CAL on strt_cal.

REQ-005 In CAL the block SHALL assert inertial_cal=1 and mtrs_off=0, hold thrst=0, and increment a calibration timer every cycle starting from 0 on entry.

REQ-006 CAL transitions SHALL be, in priority order:
- mtrs_off_cmd goes to IDLE;
- cal_done goes to RUN;
- timer equal to CAL_TMO_CYC-1 goes to FAULT and sets cal_err.

REQ-007 In RUN the block SHALL hold mtrs_off=0 and inertial_cal=0; on each vld it SHALL step thrst toward thrst_cmd by at most RAMP_STEP in either direction, never overshooting thrst_cmd.

REQ-008 The ramp arithmetic SHALL use a 10-bit unsigned intermediate so thrst+RAMP_STEP cannot wrap, and the result SHALL be clamped to [0, thrst_cmd] when stepping up and to [thrst_cmd, 511] when stepping down.

REQ-009 In RUN, ctrl_vld SHALL pulse for exactly one cycle, in the cycle after each vld, with thrst already updated in that same cycle.

REQ-010 In RUN a watchdog counter SHALL clear to 0 on vld and otherwise increment; reaching VLD_TMO_CYC-1 with no vld SHALL go to FAULT and set vld_err.

REQ-011 If vld and watchdog expiry coincide, vld SHALL win and the block SHALL stay in RUN.

REQ-012 mtrs_off_cmd in RUN SHALL go to IDLE and force thrst=0 in the next cycle, with no ramp.

REQ-013 mtrs_off_cmd SHALL take priority over every other event in CAL and RUN.

REQ-014 In FAULT the block SHALL hold mtrs_off=1, thrst=0, inertial_cal=0 and ctrl_vld=0; strt_cal SHALL go to CAL and clear both cal_err and vld_err, while mtrs_off_cmd SHALL have no effect.

REQ-015 strt_cal SHALL be ignored in CAL and RUN, and cal_done SHALL be ignored outside CAL.

REQ-016 Both timers SHALL saturate and never wrap, and SHALL be cleared on every state entry.

Reset
REQ-017 Assertion of rst_n low SHALL, asynchronously and at any time including mid-CAL or mid-RUN, force:
- state IDLE;
- mtrs_off=1, inertial_cal=0, thrst=0, ctrl_vld=0;
- cal_err=0, vld_err=0;
- both timers to 0.

REQ-018 After rst_n deasserts, the block SHALL remain in IDLE until strt_cal.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then strt_cal pulse, then cal_done 20 cycles later -> inertial_cal high for exactly those cycles, st=RUN, thrst=0.
- With CAL_TMO_CYC=100 and no cal_done -> FAULT after 100 CAL cycles, cal_err=1, mtrs_off=1; a following strt_cal clears cal_err and re-enters CAL.
- RUN, RAMP_STEP=8, thrst_cmd=30, four vld pulses -> thrst 8, 16, 24, 30; ctrl_vld one cycle after each vld; then thrst_cmd=0 and vld pulses -> thrst 22, 14, 6, 0.
- RUN with VLD_TMO_CYC=50 and vld withheld -> FAULT, vld_err=1, thrst=0; a repeat with vld landing on the expiry cycle -> stays in RUN.
- RUN at thrst=200, mtrs_off_cmd together with vld -> IDLE next cycle, thrst=0, no ctrl_vld.
- rst_n asserted mid-CAL -> all outputs at reset values immediately, without waiting for a clock edge.
